task_answer_arbiter: RTL and testbench

TASK_ANSWER_ARBITER -- requirements
Module: task_answer_arbiter

---
 rtl/task_arb_pkg.sv | 36 +++
 rtl/task_answer_arbiter_rr.sv | 43 ++++
 rtl/task_answer_arbiter.sv | 173 +++++++++++++++++
 tb/tb_task_answer_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/task_arb_pkg.sv
// ============================================================================
//  Module      : task_arb_pkg
//  Description : Shared types and constants for the task-answer arbiter:
//                FSM state encoding, header sync byte, header field widths
//                and the size-header word builder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package task_arb_pkg;

    // FSM state encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t c_ST_IDLE     = 2'd0;
    localparam arb_state_t c_ST_HDR_SIZE = 2'd1;
    localparam arb_state_t c_ST_HDR_LAT  = 2'd2;
    localparam arb_state_t c_ST_DATA     = 2'd3;

    // Header layout: {sync, grant, size}
    localparam int         c_HDR_SYNC_W  = 8;
    localparam int         c_HDR_GRANT_W = 8;
    localparam int         c_HDR_SIZE_W  = 16;
    localparam int         c_HDR_W       = c_HDR_SYNC_W + c_HDR_GRANT_W + c_HDR_SIZE_W;
    localparam logic [7:0] c_HDR_SYNC    = 8'hA5;

    // Build the first header word from the granted index and packet size
    function automatic logic [c_HDR_W-1:0] f_hdr_size_word(
        input logic [c_HDR_GRANT_W-1:0] grant,
        input logic [c_HDR_SIZE_W-1:0]  size
    );
        return {c_HDR_SYNC, grant, size};
    endfunction

endpackage

`default_nettype wire

// File: rtl/task_answer_arbiter_rr.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant selection. Searches the
//                request vector starting one past the last grant, wrapping
//                modulo NUM_TASKS; returns one-hot grant, index and a flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_TASKS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_TASKS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last_grant,
    output logic [NUM_TASKS-1:0] o_grant_onehot,
    output logic [IDX_W-1:0]     o_grant_idx,
    output logic                 o_grant_valid
);

    // Walk offsets 1..NUM_TASKS from the last grant; first requester wins
    always_comb begin
        int cand;
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        o_grant_valid  = 1'b0;
        cand           = 0;
        for (int k = 1; k <= NUM_TASKS; k++) begin
            cand = int'(i_last_grant) + k;
            if (cand >= NUM_TASKS) cand = cand - NUM_TASKS;
            for (int j = 0; j < NUM_TASKS; j++) begin
                if (!o_grant_valid && i_req[j] && (cand == j)) begin
                    o_grant_valid     = 1'b1;
                    o_grant_idx       = IDX_W'(j);
                    o_grant_onehot[j] = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/task_answer_arbiter.sv
// ============================================================================
//  Module      : task_answer_arbiter
//  Description : Round-robin packet arbiter merging per-task answer streams
//                into one stream toward a UART TX. Grant is locked for a
//                whole packet. Optional two-word header (size, latency) is
//                enabled by defining TASK_ARB_HEADER_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module task_answer_arbiter
    import task_arb_pkg::*;
#(
    parameter int NUM_TASKS  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [NUM_TASKS-1:0]            i_req_valid,
    input  logic [NUM_TASKS*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_TASKS-1:0]            i_req_last,
    input  logic [NUM_TASKS*32-1:0]         i_req_size,
    input  logic [NUM_TASKS*32-1:0]         i_req_latency,
    output logic [NUM_TASKS-1:0]            o_req_ready,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic                            o_valid,
    output logic                            o_last,
    input  logic                            i_ready,
    output logic [3:0]                      o_grant_id,
    output logic                            o_busy,
    output logic [15:0]                     o_pkt_count
);

    localparam int IDX_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;

    arb_state_t             r_state;
    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       r_last_grant;
    logic [15:0]            r_pkt_count;

    logic [NUM_TASKS-1:0]   w_arb_onehot;
    logic [IDX_W-1:0]       w_arb_idx;
    logic                   w_arb_valid;
    logic                   w_last_beat;
    logic [DATA_WIDTH-1:0]  w_data [NUM_TASKS];

    genvar g;
    generate
        for (g = 0; g < NUM_TASKS; g++) begin : g_unpack_data
            assign w_data[g] = i_req_data[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NUM_TASKS (NUM_TASKS),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .i_req          (i_req_valid),
        .i_last_grant   (r_last_grant),
        .o_grant_onehot (w_arb_onehot),
        .o_grant_idx    (w_arb_idx),
        .o_grant_valid  (w_arb_valid)
    );

    assign w_last_beat = (r_state == c_ST_DATA) && i_req_valid[r_grant]
                         && i_req_last[r_grant] && i_ready;

`ifdef TASK_ARB_HEADER_EN
    logic [31:0] r_size;
    logic [31:0] r_lat;
    logic [31:0] w_size [NUM_TASKS];
    logic [31:0] w_lat  [NUM_TASKS];
    logic        w_unused;

    generate
        for (g = 0; g < NUM_TASKS; g++) begin : g_unpack_hdr
            assign w_size[g] = i_req_size[g*32 +: 32];
            assign w_lat[g]  = i_req_latency[g*32 +: 32];
        end
    endgenerate

    // Only the low size bits travel in the header
    assign w_unused = ^{w_arb_onehot, r_size[31:c_HDR_SIZE_W]};

    // Snapshot size and latency of the requester at grant time
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_size <= '0;
            r_lat  <= '0;
        end else if ((r_state == c_ST_IDLE) && w_arb_valid) begin
            r_size <= w_size[w_arb_idx];
            r_lat  <= w_lat[w_arb_idx];
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{w_arb_onehot, i_req_size, i_req_latency};
`endif

    // Packet FSM: grant, optional headers, locked data phase
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_TASKS - 1);
            r_pkt_count  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant <= w_arb_idx;
`ifdef TASK_ARB_HEADER_EN
                        r_state <= c_ST_HDR_SIZE;
`else
                        r_state <= c_ST_DATA;
`endif
                    end
                end
`ifdef TASK_ARB_HEADER_EN
                c_ST_HDR_SIZE: if (i_ready) r_state <= c_ST_HDR_LAT;
                c_ST_HDR_LAT:  if (i_ready) r_state <= c_ST_DATA;
`endif
                c_ST_DATA: begin
                    if (w_last_beat) begin
                        r_state      <= c_ST_IDLE;
                        r_last_grant <= r_grant;
                        r_pkt_count  <= r_pkt_count + 16'd1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Output mux: registered header words or pass-through of granted task
    always_comb begin
        o_valid     = 1'b0;
        o_last      = 1'b0;
        o_data      = '0;
        o_req_ready = '0;
        case (r_state)
`ifdef TASK_ARB_HEADER_EN
            c_ST_HDR_SIZE: begin
                o_valid = 1'b1;
                o_data  = DATA_WIDTH'(f_hdr_size_word(8'(r_grant), r_size[c_HDR_SIZE_W-1:0]));
            end
            c_ST_HDR_LAT: begin
                o_valid = 1'b1;
                o_data  = DATA_WIDTH'(r_lat);
            end
`endif
            c_ST_DATA: begin
                o_valid              = i_req_valid[r_grant];
                o_data               = w_data[r_grant];
                o_last               = i_req_last[r_grant];
                o_req_ready[r_grant] = i_ready;
            end
            default: ;
        endcase
    end

    // Zero-extend the grant index onto the fixed 4-bit status port
    always_comb begin
        o_grant_id             = '0;
        o_grant_id[IDX_W-1:0]  = r_grant;
    end

    assign o_busy      = (r_state != c_ST_IDLE);
    assign o_pkt_count = r_pkt_count;

endmodule

`default_nettype wire

// File: tb/tb_task_answer_arbiter.sv
// ============================================================================
//  Module      : tb_task_answer_arbiter
//  Description : Scoreboard bench for task_answer_arbiter. Per-task source
//                queues feed the DUT; expected output words (headers when
//                TASK_ARB_HEADER_EN is defined) are queued in grant order.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_task_answer_arbiter;

    localparam int NT = 4;
    localparam int DW = 32;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [31:0] size;
        logic [31:0] lat;
    } src_word_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  gid;
        logic        is_data;
    } exp_t;

    logic              i_clk;
    logic              i_rst_n;
    logic [NT-1:0]     i_req_valid;
    logic [NT*DW-1:0]  i_req_data;
    logic [NT-1:0]     i_req_last;
    logic [NT*32-1:0]  i_req_size;
    logic [NT*32-1:0]  i_req_latency;
    logic [NT-1:0]     o_req_ready;
    logic [DW-1:0]     o_data;
    logic              o_valid;
    logic              o_last;
    logic              i_ready;
    logic [3:0]        o_grant_id;
    logic              o_busy;
    logic [15:0]       o_pkt_count;

    src_word_t src_q [NT][$];
    exp_t      sb[$];
    logic [NT-1:0] acc;
    int        rdy_mode;
    int        exp_pkts;
    int        n_checks;
    int        n_errors;

    task_answer_arbiter #(.NUM_TASKS(NT), .DATA_WIDTH(DW)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_req_valid   (i_req_valid),
        .i_req_data    (i_req_data),
        .i_req_last    (i_req_last),
        .i_req_size    (i_req_size),
        .i_req_latency (i_req_latency),
        .o_req_ready   (o_req_ready),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_last        (o_last),
        .i_ready       (i_ready),
        .o_grant_id    (o_grant_id),
        .o_busy        (o_busy),
        .o_pkt_count   (o_pkt_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Queue one packet on task t and its expected output words
    task automatic send_pkt(input int t, input int n, input logic [31:0] base,
                            input logic [31:0] size, input logic [31:0] lat);
        src_word_t w;
        exp_t      e;
`ifdef TASK_ARB_HEADER_EN
        e.data = {8'hA5, 8'(t), size[15:0]}; e.last = 1'b0; e.gid = 4'(t); e.is_data = 1'b0;
        sb.push_back(e);
        e.data = lat;
        sb.push_back(e);
`endif
        for (int i = 0; i < n; i++) begin
            w.data = base + 32'(i); w.last = (i == n - 1); w.size = size; w.lat = lat;
            src_q[t].push_back(w);
            e.data = w.data; e.last = w.last; e.gid = 4'(t); e.is_data = 1'b1;
            sb.push_back(e);
        end
        exp_pkts++;
    endtask

    task automatic wait_drain(input int budget);
        int cyc;
        cyc = 0;
        do begin
            @(negedge i_clk);
            cyc++;
        end while (!((sb.size() == 0) && !o_busy) && (cyc < budget));
        if (cyc >= budget) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(o_valid), 32'd0);
        check_eq({tag, "_last"},  32'(o_last), 32'd0);
        check_eq({tag, "_data"},  o_data, 32'd0);
        check_eq({tag, "_ready"}, 32'(o_req_ready), 32'd0);
        check_eq({tag, "_busy"},  32'(o_busy), 32'd0);
        check_eq({tag, "_gid"},   32'(o_grant_id), 32'd0);
        check_eq({tag, "_count"}, 32'(o_pkt_count), 32'd0);
    endtask

    // Source driver: retire accepted words, present queue heads, drive i_ready
    initial begin
        i_req_valid = '0; i_req_data = '0; i_req_last = '0;
        i_req_size = '0; i_req_latency = '0; i_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            for (int t = 0; t < NT; t++) begin
                if (acc[t] && (src_q[t].size() > 0)) void'(src_q[t].pop_front());
                if (src_q[t].size() > 0) begin
                    i_req_valid[t]             = 1'b1;
                    i_req_data[t*DW +: DW]     = src_q[t][0].data;
                    i_req_last[t]              = src_q[t][0].last;
                    i_req_size[t*32 +: 32]     = src_q[t][0].size;
                    i_req_latency[t*32 +: 32]  = src_q[t][0].lat;
                end else begin
                    i_req_valid[t]             = 1'b0;
                    i_req_data[t*DW +: DW]     = '0;
                    i_req_last[t]              = 1'b0;
                    i_req_size[t*32 +: 32]     = '0;
                    i_req_latency[t*32 +: 32]  = '0;
                end
            end
            case (rdy_mode)
                1:       i_ready = ~i_ready;
                2:       i_ready = 1'($urandom_range(0, 1));
                default: i_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: compare every valid word against scoreboard head
    initial begin
        logic [NT-1:0] exp_rdy;
        acc = '0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                acc = '0;
            end else begin
                acc     = i_req_valid & o_req_ready;
                exp_rdy = '0;
                if (o_valid) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        if (sb[0].is_data) exp_rdy[sb[0].gid] = i_ready;
                        check_eq("data", o_data, sb[0].data);
                        check_eq("last", 32'(o_last), 32'(sb[0].last));
                        check_eq("grant_id", 32'(o_grant_id), 32'(sb[0].gid));
                        if (i_ready) void'(sb.pop_front());
                    end
                end
                check_eq("req_ready", 32'(o_req_ready), 32'(exp_rdy));
            end
        end
    end

    initial begin
        n_checks = 0; n_errors = 0; exp_pkts = 0; rdy_mode = 0;
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #2 check_reset_outputs("rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Simultaneous tasks 0 and 3 after reset: 0, then 3, then 0 again
        send_pkt(0, 2, 32'h0A00_0000, 32'd8,  32'h10);
        send_pkt(3, 3, 32'h3A00_0000, 32'd12, 32'h30);
        send_pkt(0, 1, 32'h0B00_0000, 32'd4,  32'h11);
        wait_drain(300);
        check_eq("count_rr", 32'(o_pkt_count), 32'(exp_pkts));

        // Task 2, three words, size 12, latency 0x40
        send_pkt(2, 3, 32'h2200_0000, 32'd12, 32'h40);
        wait_drain(300);
        check_eq("count_basic", 32'(o_pkt_count), 32'(exp_pkts));
        check_eq("busy_idle", 32'(o_busy), 32'd0);

        // Ready toggling every cycle through headers and data
        rdy_mode = 1;
        send_pkt(3, 4, 32'h3C00_0000, 32'd16, 32'h55);
        send_pkt(1, 2, 32'h1C00_0000, 32'd8,  32'h66);
        wait_drain(400);
        check_eq("count_toggle", 32'(o_pkt_count), 32'(exp_pkts));

        // Task 1 arrives mid-packet of task 0 under random stalls
        rdy_mode = 2;
        send_pkt(0, 5, 32'h0D00_0000, 32'd20, 32'h77);
        repeat (4) @(posedge i_clk);
        send_pkt(1, 2, 32'h1D00_0000, 32'd8,  32'h88);
        wait_drain(600);
        check_eq("count_lock", 32'(o_pkt_count), 32'(exp_pkts));

        // Single-word packet
        rdy_mode = 0;
        send_pkt(1, 1, 32'hDEAD_BEEF, 32'd4, 32'h99);
        wait_drain(300);
        check_eq("count_single", 32'(o_pkt_count), 32'(exp_pkts));

        // Reset pulse during data phase of task 2
        @(negedge i_clk);
        send_pkt(2, 8, 32'h2E00_0000, 32'd32, 32'hAA);
        repeat (5) @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        for (int t = 0; t < NT; t++) src_q[t].delete();
        sb.delete();
        exp_pkts = 0;
        @(negedge i_clk);
        @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        send_pkt(2, 3, 32'h2F00_0000, 32'd12, 32'hBB);
        wait_drain(300);
        check_eq("count_after_rst", 32'(o_pkt_count), 32'(exp_pkts));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
